// File: rtl/mlp_argmax_pkg.sv
// ----------------------------------------------------------------------------
// mlp_argmax_pkg
// Shared types and default constants for the MLP output-layer argmax
// classifier.
//   state_e  : classifier FSM states (ACCUM collects beats, RESULT holds the
//              answer until the consumer takes it).
//   result_t : registered result record {idx, max, err, hit}. Its field
//              widths follow the package defaults, so a build with a
//              different class-index or data width changes the defaults here.
// ----------------------------------------------------------------------------
package mlp_argmax_pkg;

   localparam int NUM_CLASSES_DEF = 10;
   localparam int IDX_WIDTH_DEF   = 4;
   localparam int DATA_WIDTH_DEF  = 32;

   typedef enum logic {
      ACCUM  = 1'b0,
      RESULT = 1'b1
   } state_e;

   typedef struct packed {
      logic [IDX_WIDTH_DEF-1:0]  idx;
      logic [DATA_WIDTH_DEF-1:0] max;
      logic                      err;
      logic                      hit;
   } result_t;

endpackage : mlp_argmax_pkg

// File: rtl/mlp_sat_counter.sv
// ----------------------------------------------------------------------------
// mlp_sat_counter
// Saturating up-counter used for the classifier statistics.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, counter returns to 0
//   inc_i   : add one this cycle (ignored once the count is all-ones)
//   clr_i   : synchronous clear; wins over inc_i
//   cnt_o   : current count
// ----------------------------------------------------------------------------
module mlp_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic                 clr_i,
   output logic [CNT_WIDTH-1:0] cnt_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: default assignment first so every path drives cnt_d; without it
      // a missing branch would infer a latch.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : mlp_sat_counter

// File: rtl/mlp_argmax_classifier.sv
// ----------------------------------------------------------------------------
// mlp_argmax_classifier
// Consumes the output-layer neuron stream (one signed value per beat, tlast on
// the final neuron), reports the index and value of the largest neuron, and
// keeps saturating frame / correct-prediction counters against a reference
// label.
//   s00_axis_aclk    : clock, rising edge
//   s00_axis_areset  : asynchronous active-high reset
//   s00_axis_tdata   : signed neuron value
//   s00_axis_tvalid  : beat valid
//   s00_axis_tlast   : last neuron of the frame
//   s00_axis_tready  : beat accepted when tvalid & tready
//   label_i          : reference class, sampled on the frame's first beat
//   clear_stats_i    : one-cycle pulse zeroing both counters
//   res_valid_o      : result available, held until res_ready_i
//   res_ready_i      : consumer takes the result
//   res_idx_o        : argmax index (ties keep the lower index)
//   res_max_o        : maximum value
//   res_err_o        : frame length differed from NUM_CLASSES
//   res_hit_o        : res_idx_o matched the label and no error
//   total_cnt_o      : frames reported
//   correct_cnt_o    : frames reported with res_hit_o = 1
// ----------------------------------------------------------------------------
module mlp_argmax_classifier
   import mlp_argmax_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int IDX_WIDTH   = IDX_WIDTH_DEF,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  s00_axis_aclk,
   input  logic                  s00_axis_areset,
   input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                  s00_axis_tvalid,
   input  logic                  s00_axis_tlast,
   output logic                  s00_axis_tready,
   input  logic [IDX_WIDTH-1:0]  label_i,
   input  logic                  clear_stats_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [IDX_WIDTH-1:0]  res_idx_o,
   output logic [DATA_WIDTH-1:0] res_max_o,
   output logic                  res_err_o,
   output logic                  res_hit_o,
   output logic [CNT_WIDTH-1:0]  total_cnt_o,
   output logic [CNT_WIDTH-1:0]  correct_cnt_o
);

   // Beat counter must be able to hold NUM_CLASSES itself (its saturated value).
   localparam int BEAT_W = $clog2(NUM_CLASSES + 1);
   localparam logic [BEAT_W-1:0] BEAT_SAT  = BEAT_W'(NUM_CLASSES);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_CLASSES - 1);

   state_e                  state_q, state_d;
   logic                    tready_q, tready_d;
   logic                    res_valid_q, res_valid_d;
   result_t                 res_q, res_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic                    ovf_q, ovf_d;
   logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
   logic [IDX_WIDTH-1:0]    best_idx_q, best_idx_d;
   logic [IDX_WIDTH-1:0]    label_q, label_d;

   logic beat_acc;
   logic res_hs;
   logic frame_err;

   // tready_q is only ever 1 in ACCUM, so it alone qualifies a beat.
   assign beat_acc = s00_axis_tvalid & tready_q;
   assign res_hs   = res_valid_q & res_ready_i;

   always_comb begin
      state_d     = state_q;
      tready_d    = tready_q;
      res_valid_d = res_valid_q;
      res_d       = res_q;
      beat_d      = beat_q;
      ovf_d       = ovf_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      label_d     = label_q;
      frame_err   = 1'b0;

      unique case (state_q)
         ACCUM: begin
            // Also raises tready on the first clock after reset.
            tready_d = 1'b1;
            if (beat_acc) begin
               if (beat_q == '0) begin
                  best_val_d = $signed(s00_axis_tdata);
                  best_idx_d = '0;
                  label_d    = label_i;
               end else if (beat_q < BEAT_SAT) begin
                  // Strict compare: ties keep the earlier (lower) index.
                  if ($signed(s00_axis_tdata) > best_val_q) begin
                     best_val_d = $signed(s00_axis_tdata);
                     best_idx_d = IDX_WIDTH'(beat_q);
                  end
               end

               // Beats past NUM_CLASSES are excluded from the argmax.
               if (beat_q == BEAT_SAT) begin
                  ovf_d = 1'b1;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end

               if (s00_axis_tlast) begin
                  // Correct length means this tlast beat sits at index NUM_CLASSES-1.
                  frame_err   = ovf_d | (beat_q != BEAT_LAST);
                  res_d.idx   = best_idx_d;
                  res_d.max   = best_val_d;
                  res_d.err   = frame_err;
                  res_d.hit   = (best_idx_d == label_d) & ~frame_err;
                  res_valid_d = 1'b1;
                  tready_d    = 1'b0;
                  state_d     = RESULT;
               end
            end
         end

         RESULT: begin
            if (res_hs) begin
               res_valid_d = 1'b0;
               tready_d    = 1'b1;
               beat_d      = '0;
               ovf_d       = 1'b0;
               state_d     = ACCUM;
            end
         end

         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         state_q     <= ACCUM;
         tready_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         beat_q      <= '0;
         ovf_q       <= 1'b0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         label_q     <= '0;
      end else begin
         state_q     <= state_d;
         tready_q    <= tready_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
         beat_q      <= beat_d;
         ovf_q       <= ovf_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         label_q     <= label_d;
      end
   end

   assign s00_axis_tready = tready_q;
   assign res_valid_o     = res_valid_q;
   assign res_idx_o       = res_q.idx;
   assign res_max_o       = res_q.max;
   assign res_err_o       = res_q.err;
   assign res_hit_o       = res_q.hit;

   // A clear coinciding with a handshake wins inside the counter, so that
   // frame goes uncounted while the handshake itself still completes.
   mlp_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_total_cnt (
      .clk_i (s00_axis_aclk),
      .rst_i (s00_axis_areset),
      .inc_i (res_hs),
      .clr_i (clear_stats_i),
      .cnt_o (total_cnt_o)
   );

   mlp_sat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_correct_cnt (
      .clk_i (s00_axis_aclk),
      .rst_i (s00_axis_areset),
      .inc_i (res_hs & res_q.hit),
      .clr_i (clear_stats_i),
      .cnt_o (correct_cnt_o)
   );

endmodule : mlp_argmax_classifier

// File: tb/tb_mlp_argmax_classifier.sv
// ----------------------------------------------------------------------------
// tb_mlp_argmax_classifier
// Drives neuron frames into two classifier instances sharing one stimulus
// stream: a full-width build and a build with 2-bit statistics counters.
// Expected results come from a plain argmax over each frame's values and are
// queued when the frame's last beat is accepted; a monitor process pops them
// on every result handshake and tracks the expected counter values.
// ----------------------------------------------------------------------------
module tb_mlp_argmax_classifier;

   localparam int DW  = 32;
   localparam int NC  = 10;
   localparam int IW  = 4;
   localparam int CW  = 16;
   localparam int SCW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic [IW-1:0] label;
   logic          clear;
   logic          res_ready;

   logic           tready_a, valid_a, err_a, hit_a;
   logic [IW-1:0]  idx_a;
   logic [DW-1:0]  max_a;
   logic [CW-1:0]  tot_a, cor_a;

   logic           tready_b, valid_b, err_b, hit_b;
   logic [IW-1:0]  idx_b;
   logic [DW-1:0]  max_b;
   logic [SCW-1:0] tot_b, cor_b;

   always #5 clk = ~clk;

   mlp_argmax_classifier #(
      .DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW), .CNT_WIDTH(CW)
   ) dut (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .s00_axis_tdata(tdata), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
      .s00_axis_tready(tready_a), .label_i(label), .clear_stats_i(clear),
      .res_valid_o(valid_a), .res_ready_i(res_ready), .res_idx_o(idx_a),
      .res_max_o(max_a), .res_err_o(err_a), .res_hit_o(hit_a),
      .total_cnt_o(tot_a), .correct_cnt_o(cor_a)
   );

   mlp_argmax_classifier #(
      .DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW), .CNT_WIDTH(SCW)
   ) dut_small (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .s00_axis_tdata(tdata), .s00_axis_tvalid(tvalid), .s00_axis_tlast(tlast),
      .s00_axis_tready(tready_b), .label_i(label), .clear_stats_i(clear),
      .res_valid_o(valid_b), .res_ready_i(res_ready), .res_idx_o(idx_b),
      .res_max_o(max_b), .res_err_o(err_b), .res_hit_o(hit_b),
      .total_cnt_o(tot_b), .correct_cnt_o(cor_b)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [IW-1:0] idx;
      logic [DW-1:0] max;
      logic          err;
      logic          hit;
   } exp_t;

   exp_t sb_q[$];

   // Reference: argmax over the first NC values, first occurrence wins.
   function automatic exp_t ref_model(input int vals[$], input int lbl);
      exp_t e;
      int   n  = vals.size();
      int   bi = 0;
      int   bv = vals[0];
      for (int i = 1; i < n && i < NC; i++) begin
         if (vals[i] > bv) begin
            bv = vals[i];
            bi = i;
         end
      end
      e.idx = IW'(bi);
      e.max = DW'(bv);
      e.err = (n != NC);
      e.hit = (bi == lbl) && (n == NC);
      return e;
   endfunction

   // ---------------- result-ready driver ----------------
   bit   ready_force = 1'b1;
   logic ready_val   = 1'b0;

   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         res_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      int   m_tot, m_cor, s_tot, s_cor;
      logic exp_valid_next;
      logic snap_valid;
      logic hs, hit_now;
      logic [IW-1:0] snap_idx;
      logic [DW-1:0] snap_max;
      logic snap_err, snap_hit;
      exp_t e;
      m_tot = 0; m_cor = 0; s_tot = 0; s_cor = 0;
      exp_valid_next = 1'b0;
      snap_valid     = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_tready", tready_a, 0);
            check("rst_valid", valid_a, 0);
            check("rst_idx", idx_a, 0);
            check("rst_max", max_a, 0);
            check("rst_err", err_a, 0);
            check("rst_hit", hit_a, 0);
            check("rst_total", tot_a, 0);
            check("rst_correct", cor_a, 0);
            m_tot = 0; m_cor = 0; s_tot = 0; s_cor = 0;
            sb_q.delete();
            exp_valid_next = 1'b0;
            snap_valid     = 1'b0;
            continue;
         end

         if (exp_valid_next) check("latency_valid", valid_a, 1);
         if (valid_a)        check("tready_in_result", tready_a, 0);
         if (snap_valid) begin
            check("stall_valid", valid_a, 1);
            check("stall_idx", idx_a, snap_idx);
            check("stall_max", max_a, snap_max);
            check("stall_err", err_a, snap_err);
            check("stall_hit", hit_a, snap_hit);
         end

         hs      = valid_a & res_ready;
         hit_now = 1'b0;
         if (hs) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("res_idx", idx_a, e.idx);
               check("res_max", max_a, e.max);
               check("res_err", err_a, e.err);
               check("res_hit", hit_a, e.hit);
               hit_now = e.hit;
            end
         end

         check("total_cnt", tot_a, m_tot);
         check("correct_cnt", cor_a, m_cor);
         check("total_cnt_small", tot_b, s_tot);
         check("correct_cnt_small", cor_b, s_cor);

         // Counter values after the coming edge.
         if (clear) begin
            m_tot = 0; m_cor = 0; s_tot = 0; s_cor = 0;
         end else if (hs) begin
            if (m_tot < 65535) m_tot++;
            if (s_tot < 3)     s_tot++;
            if (hit_now) begin
               if (m_cor < 65535) m_cor++;
               if (s_cor < 3)     s_cor++;
            end
         end

         snap_valid     = valid_a & ~res_ready;
         snap_idx       = idx_a;
         snap_max       = max_a;
         snap_err       = err_a;
         snap_hit       = hit_a;
         exp_valid_next = tvalid & tready_a & tlast;
      end
   end

   // ---------------- stimulus ----------------
   // Entered just after a rising edge; returns just after the accepting edge.
   task automatic send_beat(input int d, input logic l, input logic [IW-1:0] lb);
      int t = 0;
      tdata  = DW'(d);
      tvalid = 1'b1;
      tlast  = l;
      label  = lb;
      @(negedge clk);
      while (!tready_a && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!tready_a) check("beat_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      label  = IW'($urandom);
   endtask

   task automatic send_frame(input int vals[$], input int lbl, input int gap_max);
      for (int i = 0; i < vals.size(); i++) begin
         if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
               @(posedge clk);
               #1;
            end
         end
         // Only the first beat carries the real label; later ones are noise.
         send_beat(vals[i], (i == vals.size() - 1), (i == 0) ? IW'(lbl) : IW'($urandom));
      end
      sb_q.push_back(ref_model(vals, lbl));
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("scoreboard_drain", sb_q.size(), 0);
   endtask

   initial begin
      int f1[$], f2[$], f3[$], fs[$], fl[$], fr[$];
      int len, lbl, t;
      tdata = '0; tvalid = 1'b0; tlast = 1'b0; label = '0; clear = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("tready_reset_release", tready_a, 0);
      @(negedge clk);
      check("tready_after_one_clk", tready_a, 1);
      @(posedge clk);
      #1;

      // Directed frames.
      ready_val = 1'b1;
      f1 = '{-5, 3, 7, 2, 7, -1, 0, 4, 6, 1};
      f2 = '{-9, -3, -8, -5, -7, -6, -4, -9, -8, -3};
      f3 = '{1, 2, 3, 4, 50, 5, 6, 7, 8, 9};
      send_frame(f1, 2, 0);
      send_frame(f2, 1, 0);
      send_frame(f3, 7, 0);
      wait_drain();
      repeat (2) @(posedge clk);
      #1;
      check("total_after_directed", tot_a, 3);
      check("correct_after_directed", cor_a, 2);
      check("small_total_sat", tot_b, 3);
      check("small_correct", cor_b, 2);

      // Result held off for 20 cycles while the next frame waits upstream.
      ready_val = 1'b0;
      send_frame(f3, 4, 0);
      tdata = DW'(f1[0]); tvalid = 1'b1; tlast = 1'b0; label = 2;
      repeat (20) begin
         @(negedge clk);
         check("stall_tready", tready_a, 0);
      end
      @(posedge clk);
      #1;
      ready_val = 1'b1;
      send_frame(f1, 2, 0);
      wait_drain();

      // Short and long frames.
      fs = '{3, 9, -2, 9, 1, 0};
      fl = {};
      for (int i = 0; i < 10; i++) fl.push_back(int'($urandom_range(0, 100)) - 50);
      fl.push_back(100);
      fl.push_back(100);
      ready_force = 1'b0;
      send_frame(fs, 1, 2);
      send_frame(fl, 10, 2);
      fr = '{42};
      send_frame(fr, 0, 0);
      wait_drain();

      // Clear coinciding with a handshake.
      ready_force = 1'b1;
      ready_val   = 1'b0;
      send_frame(f1, 2, 0);
      t = 0;
      while (!valid_a && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("valid_before_clear", valid_a, 1);
      clear     = 1'b1;
      ready_val = 1'b1;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      ready_val = 1'b0;
      @(negedge clk);
      check("clear_total", tot_a, 0);
      check("clear_correct", cor_a, 0);
      check("clear_valid_dropped", valid_a, 0);
      @(posedge clk);
      #1;

      // Five hits: the 2-bit build must saturate at 3.
      ready_val = 1'b1;
      repeat (5) send_frame(f1, 2, 0);
      wait_drain();
      repeat (2) @(posedge clk);
      #1;
      check("sat_total_full", tot_a, 5);
      check("sat_correct_full", cor_a, 5);
      check("sat_total_small", tot_b, 3);
      check("sat_correct_small", cor_b, 3);

      // Randomized frames with random gaps, back-pressure and clears.
      ready_force = 1'b0;
      for (int n = 0; n < 40; n++) begin
         fr  = {};
         case ($urandom_range(0, 7))
            0:       len = 1;
            1:       len = 6;
            2:       len = 9;
            3:       len = 11;
            4:       len = 13;
            default: len = NC;
         endcase
         lbl = $urandom_range(0, NC - 1);
         for (int i = 0; i < len; i++) begin
            if (n % 2 == 0) fr.push_back(int'($urandom_range(0, 6)) - 3);
            else            fr.push_back(int'($urandom));
         end
         send_frame(fr, lbl, 2);
         if ($urandom_range(0, 7) == 0) begin
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
         end
      end
      wait_drain();

      // Asynchronous reset after beat 5 of a frame.
      for (int i = 0; i < 5; i++) send_beat(f3[i], 1'b0, (i == 0) ? IW'(7) : IW'($urandom));
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_tready", tready_a, 0);
      check("async_rst_valid", valid_a, 0);
      check("async_rst_total", tot_a, 0);
      check("async_rst_correct", cor_a, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ready_force = 1'b1;
      ready_val   = 1'b1;
      send_frame(f1, 2, 0);
      wait_drain();
      repeat (2) @(posedge clk);
      #1;
      check("post_reset_total", tot_a, 1);
      check("post_reset_correct", cor_a, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected finish before t=500000");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mlp_argmax_classifier
